pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, giving the payload width (ALUResult+ReadData+PCPlus4).
REQ-002 The block SHALL have parameter RD_W, default 5, giving the destination-register index width.
REQ-003 The block SHALL have parameter SKID, default 1, where 1 selects a two-entry skid stage and 0 a single-entry stage.
REQ-004 The block SHALL have port i_Clk, input, 1 bit, the clock.
REQ-005 The block SHALL have port i_Reset, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port i_Flush, input, 1 bit, a synchronous squash of all held entries.
REQ-007 The block SHALL have port i_ValidIn, input, 1 bit, meaning upstream offers an entry.
REQ-008 The block SHALL have port o_ReadyOut, output, 1 bit, meaning the stage accepts an entry this cycle.
REQ-009 The block SHALL have port i_DataIn, input, DATA_W bits, the upstream payload.
REQ-010 The block SHALL have port i_RdIn, input, RD_W bits, the upstream destination index.
REQ-011 The block SHALL have port o_ValidOut, output, 1 bit, meaning the head entry is valid.
REQ-012 The block SHALL have port i_ReadyIn, input, 1 bit, meaning downstream consumes the head entry.
REQ-013 The block SHALL have port o_DataOut, output, DATA_W bits, the head payload.
REQ-014 The block SHALL have port o_RdOut, output, RD_W bits, the head destination index.
REQ-015 The block SHALL have port o_Count, output, 2 bits, giving current occupancy (0..2).

Function
REQ-016 Input fire SHALL be i_ValidIn & o_ReadyOut; output fire SHALL be o_ValidOut & i_ReadyIn.
REQ-017 With SKID=1 the block SHALL have states EMPTY, ONE and FULL, with o_ReadyOut = (state != FULL) and o_ValidOut = (state != EMPTY), both decoded from registered state only.
REQ-018 EMPTY SHALL go to ONE on input fire, loading the head slot; otherwise it SHALL stay in EMPTY.
REQ-019 ONE SHALL behave as follows: input and output fire together load the head and stay in ONE; input fire alone loads the skid slot and goes to FULL; output fire alone goes to EMPTY; with neither it SHALL hold.
REQ-020 FULL SHALL move the skid slot to the head and go to ONE on output fire; otherwise it SHALL hold, and no input is accepted in FULL.
REQ-021 With SKID=0 the block SHALL use only EMPTY and ONE, with o_ReadyOut = ~o_ValidOut | i_ReadyIn (combinational pass-through); simultaneous fires SHALL reload the head.
REQ-022 Latency from input fire to o_ValidOut SHALL be exactly 1 cycle in both modes; order SHALL be strictly FIFO.
REQ-023 o_RdOut SHALL be 0 whenever o_ValidOut is 0 (bubble writes x0); o_DataOut SHALL hold its last value when not valid.
REQ-024 i_Flush SHALL have priority over all handshakes: next state EMPTY, o_Count 0, o_RdOut 0, and any input or output fire in that cycle discarded.
REQ-025 o_Count SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL, and SHALL never reach 2 when SKID=0.
REQ-026 Held payload SHALL not change while i_ReadyIn is low (stall), regardless of i_DataIn.

Reset
REQ-027 While i_Reset is low, the state SHALL be EMPTY, both slots zero, o_ValidOut 0, o_DataOut 0, o_RdOut 0 and o_Count 0.
REQ-028 o_ReadyOut SHALL read 1 in the reset state with SKID=1, and SHALL read 1 with SKID=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-030 The shared package pipe_pkg SHALL hold the state enum typedef (EMPTY, ONE, FULL), constant RD_X0 = 0 and the default RD_W.
REQ-031 The block SHALL instantiate one sub-module, pipe_slot (DATA_W+RD_W register with load enable, async active-low reset), twice: head and skid; with SKID=0 the skid instance SHALL be omitted via generate.

Verification
REQ-032 Reset release, then push D=0xA,Rd=3 with i_ReadyIn=1 -> next cycle o_ValidOut=1, o_DataOut=0xA, o_RdOut=3, o_Count=1.
REQ-033 SKID=1 with i_ReadyIn=0, push 0x1 then 0x2 -> o_Count=2, o_ReadyOut=0, a third push of 0x3 is refused; raise i_ReadyIn -> output 0x1 then 0x2 in order.
REQ-034 SKID=1 streaming 100 entries with random i_ReadyIn -> no loss, no duplication, FIFO order preserved.
REQ-035 FULL with i_Flush=1 and i_ValidIn=1 simultaneously -> next cycle EMPTY, o_ValidOut=0, o_RdOut=0, input not captured.
REQ-036 SKID=0, state ONE with i_ReadyIn=1 and i_ValidIn=1 (D=0x5) -> o_ReadyOut=1 the same cycle, head becomes 0x5, o_Count stays 1.
REQ-037 Assert i_Reset mid-cycle while FULL -> outputs zero before the next edge; after release o_ReadyOut=1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the pipeline-stage skid buffer.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   localparam int RD_X0    = 0;
   localparam int RD_W_DEF = 5;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One payload register with load enable; cleared by the asynchronous active-low reset.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset)
         q_q <= '0;
      else if (load_i)
         q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage: two-entry skid buffer (SKID=1) or single-entry stage (SKID=0).
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = 96,
   parameter int RD_W   = RD_W_DEF,
   parameter bit SKID   = 1'b1
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_Flush,
   input  logic              i_ValidIn,
   output logic              o_ReadyOut,
   input  logic [DATA_W-1:0] i_DataIn,
   input  logic [RD_W-1:0]   i_RdIn,
   output logic              o_ValidOut,
   input  logic              i_ReadyIn,
   output logic [DATA_W-1:0] o_DataOut,
   output logic [RD_W-1:0]   o_RdOut,
   output logic [1:0]        o_Count
);

   localparam int PL_W = DATA_W + RD_W;

   state_e            state_q, state_d;
   logic [PL_W-1:0]   head_q, skid_q, head_d, in_pl;
   logic              head_load, skid_load;
   logic              valid, ready, in_fire, out_fire;

   assign in_pl    = {i_DataIn, i_RdIn};
   assign valid    = (state_q != EMPTY);
   assign in_fire  = i_ValidIn & ready;
   assign out_fire = valid & i_ReadyIn;

   // Skid mode decodes ready from registered state; single-entry mode passes ready through.
   if (SKID) begin : g_ready_skid
      assign ready = (state_q != FULL);
   end else begin : g_ready_pass
      assign ready = ~valid | i_ReadyIn;
   end

   always_comb begin
      state_d   = state_q;
      head_load = 1'b0;
      skid_load = 1'b0;
      head_d    = in_pl;
      if (i_Flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  head_load = 1'b1;
                  state_d   = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  head_load = 1'b1;
               end else if (in_fire && SKID) begin
                  skid_load = 1'b1;
                  state_d   = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  head_load = 1'b1;
                  head_d    = skid_q;
                  state_d   = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   pipe_slot #(.W(PL_W)) u_head (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .load_i  (head_load),
      .d_i     (head_d),
      .q_o     (head_q)
   );

   if (SKID) begin : g_skid
      pipe_slot #(.W(PL_W)) u_skid (
         .i_Clk   (i_Clk),
         .i_Reset (i_Reset),
         .load_i  (skid_load),
         .d_i     (in_pl),
         .q_o     (skid_q)
      );
   end else begin : g_noskid
      logic unused_skid;
      assign skid_q      = '0;
      assign unused_skid = skid_load;
   end

   // Bubbles present x0 so a downstream writeback never targets a live register.
   assign o_ReadyOut = ready;
   assign o_ValidOut = valid;
   assign o_DataOut  = head_q[PL_W-1:RD_W];
   assign o_RdOut    = valid ? head_q[RD_W-1:0] : RD_W'(RD_X0);
   assign o_Count    = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid in both SKID modes against a queue model.
module tb_pipe_stage_skid;

   localparam int DW = 96;
   localparam int RW = 5;

   typedef logic [DW+RW-1:0] ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vin, flush, rdy;
   logic [DW-1:0] din;
   logic [RW-1:0] rdin;

   logic          rdyo1, vo1, rdyo0, vo0;
   logic [DW-1:0] do1, do0;
   logic [RW-1:0] rdo1, rdo0;
   logic [1:0]    cnt1, cnt0;

   int            checks = 0;
   int            errors = 0;
   int            acc1   = 0;
   ent_t          q1[$];
   ent_t          q0[$];
   logic [DW-1:0] last1, last0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .RD_W(RW), .SKID(1'b1)) dut1 (
      .i_Clk(clk), .i_Reset(rst_n), .i_Flush(flush), .i_ValidIn(vin), .o_ReadyOut(rdyo1),
      .i_DataIn(din), .i_RdIn(rdin), .o_ValidOut(vo1), .i_ReadyIn(rdy),
      .o_DataOut(do1), .o_RdOut(rdo1), .o_Count(cnt1)
   );

   pipe_stage_skid #(.DATA_W(DW), .RD_W(RW), .SKID(1'b0)) dut0 (
      .i_Clk(clk), .i_Reset(rst_n), .i_Flush(flush), .i_ValidIn(vin), .o_ReadyOut(rdyo0),
      .i_DataIn(din), .i_RdIn(rdin), .o_ValidOut(vo0), .i_ReadyIn(rdy),
      .o_DataOut(do0), .o_RdOut(rdo0), .o_Count(cnt0)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      ent_t h1, h0;
      h1 = (q1.size() > 0) ? q1[0] : '0;
      h0 = (q0.size() > 0) ? q0[0] : '0;
      chk("valid1", vo1, DW'(q1.size() > 0));
      chk("count1", cnt1, DW'(q1.size()));
      chk("rd1",    rdo1, (q1.size() > 0) ? DW'(h1[RW-1:0]) : '0);
      chk("data1",  do1,  (q1.size() > 0) ? h1[DW+RW-1:RW] : last1);
      chk("valid0", vo0, DW'(q0.size() > 0));
      chk("count0", cnt0, DW'(q0.size()));
      chk("rd0",    rdo0, (q0.size() > 0) ? DW'(h0[RW-1:0]) : '0);
      chk("data0",  do0,  (q0.size() > 0) ? h0[DW+RW-1:RW] : last0);
   endtask

   // One clock of stimulus applied to both instances; models advance on the edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] r,
                       input logic rd_in, input logic fl);
      logic er1, er0, in1, out1, in0, out0;
      vin = v; din = d; rdin = r; rdy = rd_in; flush = fl;
      #1;
      er1 = (q1.size() < 2);
      er0 = (q0.size() == 0) || rd_in;
      chk("ready1", rdyo1, DW'(er1));
      chk("ready0", rdyo0, DW'(er0));
      in1  = v && er1;
      out1 = (q1.size() > 0) && rd_in;
      in0  = v && er0;
      out0 = (q0.size() > 0) && rd_in;
      @(posedge clk);
      if (fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (out1) void'(q1.pop_front());
         if (in1) begin
            q1.push_back({d, r});
            acc1++;
         end
         if (out0) void'(q0.pop_front());
         if (in0) q0.push_back({d, r});
      end
      if (q1.size() > 0) last1 = q1[0][DW+RW-1:RW];
      if (q0.size() > 0) last0 = q0[0][DW+RW-1:RW];
      #1;
      check_out();
   endtask

   initial begin
      logic [DW-1:0] rd_data;
      rst_n = 1'b0; vin = 1'b0; flush = 1'b0; rdy = 1'b0; din = '0; rdin = '0;
      last1 = '0; last0 = '0;
      #1;
      check_out();
      chk("rst_ready1", rdyo1, 1);
      chk("rst_ready0", rdyo0, 1);
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single push, one-cycle latency.
      step(1'b1, 'hA, 5'd3, 1'b1, 1'b0);
      chk("push_valid", vo1, 1);
      chk("push_data", do1, 'hA);
      chk("push_rd", rdo1, 3);
      chk("push_count", cnt1, 1);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // Stall fill, refused third push, ordered drain.
      step(1'b1, 'h1, 5'd1, 1'b0, 1'b0);
      step(1'b1, 'h2, 5'd2, 1'b0, 1'b0);
      chk("full_count", cnt1, 2);
      chk("full_ready", rdyo1, 0);
      step(1'b1, 'h3, 5'd3, 1'b0, 1'b0);
      chk("refused_count", cnt1, 2);
      chk("refused_head", do1, 'h1);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_second", do1, 'h2);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_empty", vo1, 0);

      // Flush while full with a concurrent offer, then flush with both fires in ONE.
      step(1'b1, 'h4, 5'd4, 1'b0, 1'b0);
      step(1'b1, 'h5, 5'd5, 1'b0, 1'b0);
      step(1'b1, 'h6, 5'd6, 1'b0, 1'b1);
      chk("flush_valid", vo1, 0);
      chk("flush_rd", rdo1, 0);
      step(1'b1, 'h7, 5'd7, 1'b0, 1'b0);
      step(1'b1, 'h8, 5'd8, 1'b1, 1'b1);
      chk("flush_one_count", cnt1, 0);

      // Single-entry mode: simultaneous fires reload the head.
      step(1'b1, 'h4, 5'd4, 1'b0, 1'b0);
      step(1'b1, 'h5, 5'd5, 1'b1, 1'b0);
      chk("pass_head", do0, 'h5);
      chk("pass_count", cnt0, 1);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // Random streaming with random back-pressure and stall-time data churn.
      acc1 = 0;
      for (int i = 0; i < 600 && acc1 < 100; i++) begin
         rd_data = {$urandom, $urandom, $urandom};
         step(1'($urandom_range(0, 3) != 0), rd_data, 5'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("stream_budget", (acc1 >= 100) ? 1 : 0, 1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

      // Asynchronous reset while full.
      step(1'b1, 'h11, 5'd11, 1'b0, 1'b0);
      step(1'b1, 'h12, 5'd12, 1'b0, 1'b0);
      chk("pre_reset_count", cnt1, 2);
      vin = 1'b0; rdy = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      q1.delete(); q0.delete();
      last1 = '0; last0 = '0;
      check_out();
      #2 rst_n = 1'b1;
      #1;
      chk("post_reset_ready1", rdyo1, 1);
      chk("post_reset_ready0", rdyo0, 1);
      @(posedge clk);
      #1;
      check_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
